// File: rtl/cabac_ctx_update_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// cabac_ctx_update_ctrl_pkg : shared sizes, FSM encoding and HEVC state
//                             transition helpers for the context updater
// Revision 1.0
// ============================================================================
package cabac_ctx_update_ctrl_pkg;

    localparam int CTX_NUM_DEF = 512;
    localparam int IDX_W       = 9;
    localparam int CTX_W       = 7;
    localparam int PST_W       = 6;

    localparam logic [PST_W-1:0] PSTATE_MPS_SAT = 6'd62;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } ctrl_state_e;

    localparam logic [PST_W-1:0] TRANS_IDX_LPS [64] = '{
        6'd0,  6'd0,  6'd1,  6'd2,  6'd2,  6'd4,  6'd4,  6'd5,
        6'd6,  6'd7,  6'd8,  6'd9,  6'd9,  6'd11, 6'd11, 6'd12,
        6'd13, 6'd13, 6'd15, 6'd15, 6'd16, 6'd16, 6'd18, 6'd18,
        6'd19, 6'd19, 6'd21, 6'd21, 6'd22, 6'd22, 6'd23, 6'd24,
        6'd24, 6'd25, 6'd26, 6'd26, 6'd27, 6'd27, 6'd28, 6'd29,
        6'd29, 6'd30, 6'd30, 6'd30, 6'd31, 6'd32, 6'd32, 6'd33,
        6'd33, 6'd33, 6'd34, 6'd34, 6'd35, 6'd35, 6'd35, 6'd36,
        6'd36, 6'd36, 6'd37, 6'd37, 6'd37, 6'd38, 6'd38, 6'd63
    };

    // Context layout is {mps, pstate}; pstate 63 is a fixed state for MPS bins.
    function automatic logic [CTX_W-1:0] ctx_apply_bin(
        input logic [CTX_W-1:0] ctx,
        input logic             bin
    );
        logic             mps;
        logic [PST_W-1:0] pst;
        mps = ctx[CTX_W-1];
        pst = ctx[PST_W-1:0];
        if (bin == mps) begin
            if (pst < PSTATE_MPS_SAT) begin
                pst = pst + 6'd1;
            end
        end else begin
            if (pst == '0) begin
                mps = ~mps;
            end
            pst = TRANS_IDX_LPS[pst];
        end
        return {mps, pst};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cabac_ctx_next_state.sv
`default_nettype none
// ============================================================================
// cabac_ctx_next_state : combinational context update for one or two bins
// Revision 1.0
// ============================================================================
module cabac_ctx_next_state
    import cabac_ctx_update_ctrl_pkg::*;
(
    input  logic [CTX_W-1:0] ctx_i,
    input  logic             bin0_i,
    input  logic             bin1_i,
    input  logic             two_i,
    output logic [CTX_W-1:0] ctx_o
);

    logic [CTX_W-1:0] w_after_bin0;
    logic [CTX_W-1:0] w_after_bin1;

    assign w_after_bin0 = ctx_apply_bin(ctx_i, bin0_i);
    assign w_after_bin1 = ctx_apply_bin(w_after_bin0, bin1_i);
    assign ctx_o        = two_i ? w_after_bin1 : w_after_bin0;

endmodule
`default_nettype wire

// File: rtl/cabac_ctx_update_ctrl.sv
`default_nettype none
// ============================================================================
// cabac_ctx_update_ctrl : context table init and 3-stage read/update/write
//                         pipeline with forwarding for back-to-back updates
// Revision 1.0
// ============================================================================
module cabac_ctx_update_ctrl
    import cabac_ctx_update_ctrl_pkg::*;
#(
    parameter int CTX_NUM = CTX_NUM_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_start_i,
    output logic [IDX_W-1:0] init_idx_o,
    input  logic [CTX_W-1:0] init_val_i,
    output logic             init_done_o,
    input  logic             upd_valid_i,
    output logic             upd_ready_o,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_two_i,
    input  logic             upd_bin0_i,
    input  logic             upd_bin1_i,
    output logic             ctx_valid_o,
    output logic [CTX_W-1:0] ctx_o,
    output logic             mem_rd_en_o,
    output logic [IDX_W-1:0] mem_rd_addr_o,
    input  logic [CTX_W-1:0] mem_rd_data_i,
    output logic             mem_wr_en_o,
    output logic [IDX_W-1:0] mem_wr_addr_o,
    output logic [CTX_W-1:0] mem_wr_data_o
);

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(CTX_NUM - 1);

    ctrl_state_e      state_q;
    ctrl_state_e      state_d;
    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] cnt_d;

    logic             s1_valid_q;
    logic [IDX_W-1:0] s1_idx_q;
    logic             s1_two_q;
    logic             s1_bin0_q;
    logic             s1_bin1_q;

    logic             s2_valid_q;
    logic [IDX_W-1:0] s2_idx_q;
    logic [CTX_W-1:0] s2_data_q;

    logic             lw_valid_q;
    logic [IDX_W-1:0] lw_idx_q;
    logic [CTX_W-1:0] lw_data_q;

    logic             w_accept;
    logic             w_cnt_last;
    logic [CTX_W-1:0] w_fwd_ctx;
    logic [CTX_W-1:0] w_next_ctx;

    assign w_accept   = upd_valid_i && (state_q == ST_RUN);
    assign w_cnt_last = (cnt_q == C_LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DRAIN leaves once S1 is empty: the S2 write still in flight lands this cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (init_start_i) state_d = ST_INIT;
            end
            ST_INIT: begin
                cnt_d = w_cnt_last ? '0 : cnt_q + IDX_W'(1);
                if (w_cnt_last) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (init_start_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!s1_valid_q) state_d = ST_INIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        init_idx_o    = '0;
        init_done_o   = 1'b0;
        upd_ready_o   = 1'b0;
        mem_wr_en_o   = 1'b0;
        mem_wr_addr_o = '0;
        mem_wr_data_o = '0;
        case (state_q)
            ST_INIT: begin
                init_idx_o    = cnt_q;
                mem_wr_en_o   = 1'b1;
                mem_wr_addr_o = cnt_q;
                mem_wr_data_o = init_val_i;
            end
            ST_RUN: begin
                init_done_o = 1'b1;
                upd_ready_o = 1'b1;
            end
            default: ;
        endcase
        if (s2_valid_q) begin
            mem_wr_en_o   = 1'b1;
            mem_wr_addr_o = s2_idx_q;
            mem_wr_data_o = s2_data_q;
        end
    end

    assign mem_rd_en_o   = w_accept;
    assign mem_rd_addr_o = w_accept ? upd_idx_i : '0;

    // The RAM read lags writes by up to two cycles; newest pending value wins.
    always_comb begin
        if (s2_valid_q && (s2_idx_q == s1_idx_q)) begin
            w_fwd_ctx = s2_data_q;
        end else if (lw_valid_q && (lw_idx_q == s1_idx_q)) begin
            w_fwd_ctx = lw_data_q;
        end else begin
            w_fwd_ctx = mem_rd_data_i;
        end
    end

    assign ctx_valid_o = s1_valid_q;
    assign ctx_o       = s1_valid_q ? w_fwd_ctx : '0;

    cabac_ctx_next_state u_next_state (
        .ctx_i  (w_fwd_ctx),
        .bin0_i (s1_bin0_q),
        .bin1_i (s1_bin1_q),
        .two_i  (s1_two_q),
        .ctx_o  (w_next_ctx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            s1_two_q   <= 1'b0;
            s1_bin0_q  <= 1'b0;
            s1_bin1_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_idx_q   <= '0;
            s2_data_q  <= '0;
            lw_valid_q <= 1'b0;
            lw_idx_q   <= '0;
            lw_data_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            s1_valid_q <= w_accept;
            if (w_accept) begin
                s1_idx_q  <= upd_idx_i;
                s1_two_q  <= upd_two_i;
                s1_bin0_q <= upd_bin0_i;
                s1_bin1_q <= upd_bin1_i;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_idx_q  <= s1_idx_q;
                s2_data_q <= w_next_ctx;
            end
            lw_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                lw_idx_q  <= s2_idx_q;
                lw_data_q <= s2_data_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cabac_ctx_update_ctrl.sv
`default_nettype none
// ============================================================================
// tb_cabac_ctx_update_ctrl : self-checking bench with a sequential context model
// Revision 1.0
// ============================================================================
module tb_cabac_ctx_update_ctrl;

    localparam int N = 512;

    localparam int LPS_REF [64] = '{
        0, 0, 1, 2, 2, 4, 4, 5, 6, 7, 8, 9, 9, 11, 11, 12,
        13, 13, 15, 15, 16, 16, 18, 18, 19, 19, 21, 21, 22, 22, 23, 24,
        24, 25, 26, 26, 27, 27, 28, 29, 29, 30, 30, 30, 31, 32, 32, 33,
        33, 33, 34, 34, 35, 35, 35, 36, 36, 36, 37, 37, 37, 38, 38, 63
    };

    // directed cases: start ctx, two, bin0, bin1, expected written ctx
    localparam logic [6:0] DIR_START [7] = '{7'h40, 7'h4A, 7'h4A, 7'h3E, 7'h3F, 7'h00, 7'h3D};
    localparam logic       DIR_TWO   [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic       DIR_B0    [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic       DIR_B1    [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [6:0] DIR_EXP   [7] = '{7'h00, 7'h48, 7'h46, 7'h3E, 7'h3F, 7'h40, 7'h3E};
    localparam logic [6:0] B2B_EXP   [3] = '{7'd5, 7'd7, 7'd9};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_start_i = 1'b0;
    logic [8:0] init_idx_o;
    logic [6:0] init_val_i;
    logic       init_done_o;
    logic       upd_valid_i = 1'b0;
    logic       upd_ready_o;
    logic [8:0] upd_idx_i = '0;
    logic       upd_two_i = 1'b0;
    logic       upd_bin0_i = 1'b0;
    logic       upd_bin1_i = 1'b0;
    logic       ctx_valid_o;
    logic [6:0] ctx_o;
    logic       mem_rd_en_o;
    logic [8:0] mem_rd_addr_o;
    logic [6:0] mem_rd_data_i = '0;
    logic       mem_wr_en_o;
    logic [8:0] mem_wr_addr_o;
    logic [6:0] mem_wr_data_o;

    logic [6:0] ram      [N];
    logic [6:0] ref_tab  [N];
    logic [6:0] init_tab [N];
    logic       pre_en   = 1'b0;
    logic [8:0] pre_addr = '0;
    logic [6:0] pre_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    cabac_ctx_update_ctrl #(.CTX_NUM(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .init_start_i  (init_start_i),
        .init_idx_o    (init_idx_o),
        .init_val_i    (init_val_i),
        .init_done_o   (init_done_o),
        .upd_valid_i   (upd_valid_i),
        .upd_ready_o   (upd_ready_o),
        .upd_idx_i     (upd_idx_i),
        .upd_two_i     (upd_two_i),
        .upd_bin0_i    (upd_bin0_i),
        .upd_bin1_i    (upd_bin1_i),
        .ctx_valid_o   (ctx_valid_o),
        .ctx_o         (ctx_o),
        .mem_rd_en_o   (mem_rd_en_o),
        .mem_rd_addr_o (mem_rd_addr_o),
        .mem_rd_data_i (mem_rd_data_i),
        .mem_wr_en_o   (mem_wr_en_o),
        .mem_wr_addr_o (mem_wr_addr_o),
        .mem_wr_data_o (mem_wr_data_o)
    );

    always #5 clk = ~clk;

    assign init_val_i = init_tab[init_idx_o];

    // read-first context RAM; pre_* is a bench-side preload path
    always @(posedge clk) begin
        if (mem_rd_en_o) mem_rd_data_i <= ram[mem_rd_addr_o];
        if (mem_wr_en_o) ram[mem_wr_addr_o] <= mem_wr_data_o;
        if (pre_en) ram[pre_addr] <= pre_data;
    end

    function automatic logic [6:0] ref_bin(input logic [6:0] c, input logic b);
        int   p;
        logic m;
        m = c[6];
        p = int'(c[5:0]);
        if (b == m) begin
            if (p < 62) p = p + 1;
        end else begin
            if (p == 0) m = ~m;
            p = LPS_REF[p];
        end
        return {m, p[5:0]};
    endfunction

    function automatic logic [6:0] ref_upd(input logic [6:0] c, input logic two,
                                           input logic b0, input logic b1);
        logic [6:0] r;
        r = ref_bin(c, b0);
        if (two) r = ref_bin(r, b1);
        return r;
    endfunction

    function automatic logic [45:0] outs_vec();
        return {init_idx_o, init_done_o, upd_ready_o, ctx_valid_o, ctx_o, mem_rd_en_o,
                mem_rd_addr_o, mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic preload(input int idx, input logic [6:0] v);
        pre_en   = 1'b1;
        pre_addr = idx[8:0];
        pre_data = v;
        tick();
        pre_en       = 1'b0;
        ref_tab[idx] = v;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        upd_valid_i = 1'b1;
        upd_idx_i   = 9'h1AB;
        #2;
        n_tests++;
        if (outs_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", outs_vec());
        end
        @(negedge clk);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (upd_ready_o !== 1'b0 || mem_rd_en_o !== 1'b0 || mem_wr_en_o !== 1'b0 ||
                ctx_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_quiet: ready=%b rd=%b wr=%b cv=%b required all 0",
                         upd_ready_o, mem_rd_en_o, mem_wr_en_o, ctx_valid_o);
            end
        end
        upd_valid_i = 1'b0;
    endtask

    task automatic test_init();
        int cyc;
        int idx_err;
        int ram_err;
        int first_bad;
        for (int k = 0; k < N; k++) init_tab[k] = 7'(k);
        init_start_i = 1'b1;
        tick();
        init_start_i = 1'b0;
        n_tests++;
        if (mem_wr_en_o !== 1'b1 || mem_wr_addr_o !== 9'd0 || mem_wr_data_o !== 7'd0 ||
            upd_ready_o !== 1'b0 || init_done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL init_first: wr=%b addr=%0d data=%0d rdy=%b done=%b required 1,0,0,0,0",
                     mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o, upd_ready_o, init_done_o);
        end
        cyc     = 0;
        idx_err = 0;
        while (init_done_o !== 1'b1 && cyc < 2 * N) begin
            if (init_idx_o !== cyc[8:0] || mem_wr_en_o !== 1'b1) idx_err++;
            init_start_i = (cyc == 200);
            tick();
            cyc++;
        end
        init_start_i = 1'b0;
        n_tests++;
        if (idx_err != 0) begin
            n_fail++;
            $display("FAIL init_counter: %0d bad cycles required 0", idx_err);
        end
        n_tests++;
        if (cyc != N) begin
            n_fail++;
            $display("FAIL init_latency: got %0d cycles required %0d", cyc, N);
        end
        n_tests++;
        if (upd_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL run_ready: got %b required 1", upd_ready_o);
        end
        ram_err   = 0;
        first_bad = -1;
        for (int k = 0; k < N; k++) begin
            ref_tab[k] = 7'(k);
            if (ram[k] !== 7'(k)) begin
                ram_err++;
                if (first_bad < 0) first_bad = k;
            end
        end
        n_tests++;
        if (ram_err != 0) begin
            n_fail++;
            $display("FAIL init_table: %0d bad entries (first idx %0d got %h) required 0",
                     ram_err, first_bad, (first_bad >= 0) ? ram[first_bad] : 7'h0);
        end
    endtask

    task automatic test_next_state();
        int idx;
        for (int i = 0; i < 7; i++) begin
            idx = 30 + i;
            preload(idx, DIR_START[i]);
            upd_valid_i = 1'b1;
            upd_idx_i   = idx[8:0];
            upd_two_i   = DIR_TWO[i];
            upd_bin0_i  = DIR_B0[i];
            upd_bin1_i  = DIR_B1[i];
            #1;
            n_tests++;
            if (mem_rd_en_o !== 1'b1 || mem_rd_addr_o !== idx[8:0]) begin
                n_fail++;
                $display("FAIL dir%0d_read: en=%b addr=%0d required 1,%0d",
                         i, mem_rd_en_o, mem_rd_addr_o, idx);
            end
            tick();
            upd_valid_i = 1'b0;
            n_tests++;
            if (ctx_valid_o !== 1'b1 || ctx_o !== DIR_START[i]) begin
                n_fail++;
                $display("FAIL dir%0d_ctx: valid=%b ctx=%h required 1,%h",
                         i, ctx_valid_o, ctx_o, DIR_START[i]);
            end
            tick();
            n_tests++;
            if (mem_wr_en_o !== 1'b1 || mem_wr_addr_o !== idx[8:0] || mem_wr_data_o !== DIR_EXP[i]) begin
                n_fail++;
                $display("FAIL dir%0d_write: en=%b addr=%0d data=%h required 1,%0d,%h",
                         i, mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o, idx, DIR_EXP[i]);
            end
            ref_tab[idx] = DIR_EXP[i];
            tick();
        end
    endtask

    task automatic test_back_to_back();
        preload(5, 7'h05);
        upd_idx_i  = 9'd5;
        upd_two_i  = 1'b1;
        upd_bin0_i = 1'b0;
        upd_bin1_i = 1'b0;
        for (int j = 0; j < 5; j++) begin
            upd_valid_i = (j < 3);
            if (j >= 1 && j <= 3) begin
                n_tests++;
                if (ctx_valid_o !== 1'b1 || ctx_o !== B2B_EXP[j-1]) begin
                    n_fail++;
                    $display("FAIL b2b_ctx%0d: valid=%b ctx=%0d required 1,%0d",
                             j - 1, ctx_valid_o, ctx_o, B2B_EXP[j-1]);
                end
            end
            tick();
        end
        upd_valid_i = 1'b0;
        tick();
        n_tests++;
        if (ram[5] !== 7'd11) begin
            n_fail++;
            $display("FAIL b2b_final: got %h required %h", ram[5], 7'd11);
        end
        ref_tab[5] = 7'd11;
    endtask

    task automatic test_random();
        int         idx;
        logic       v, two, b0, b1;
        logic       acc1, acc2;
        logic [8:0] idx1, idx2;
        logic [6:0] pre1, post1, post2;
        int         ram_err;
        for (int k = 0; k < 8; k++) preload(k, 7'($urandom_range(0, 127)));
        acc1 = 1'b0; acc2 = 1'b0;
        idx1 = '0;   idx2 = '0;
        pre1 = '0;   post1 = '0; post2 = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            n_tests++;
            if (ctx_valid_o !== acc1 || (acc1 && ctx_o !== pre1)) begin
                n_fail++;
                $display("FAIL rnd_ctx@%0d: valid=%b ctx=%h required %b,%h",
                         cyc, ctx_valid_o, ctx_o, acc1, pre1);
            end
            n_tests++;
            if (mem_wr_en_o !== acc2 ||
                (acc2 && (mem_wr_addr_o !== idx2 || mem_wr_data_o !== post2))) begin
                n_fail++;
                $display("FAIL rnd_wr@%0d: en=%b addr=%0d data=%h required %b,%0d,%h",
                         cyc, mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o, acc2, idx2, post2);
            end
            acc2  = acc1;
            idx2  = idx1;
            post2 = post1;
            v   = (cyc < 390) && ($urandom_range(0, 9) < 7);
            idx = $urandom_range(0, 7);
            two = 1'($urandom_range(0, 1));
            b0  = 1'($urandom_range(0, 1));
            b1  = 1'($urandom_range(0, 1));
            upd_valid_i = v;
            upd_idx_i   = idx[8:0];
            upd_two_i   = two;
            upd_bin0_i  = b0;
            upd_bin1_i  = b1;
            #1;
            n_tests++;
            if (mem_rd_en_o !== v || (v && mem_rd_addr_o !== idx[8:0])) begin
                n_fail++;
                $display("FAIL rnd_rd@%0d: en=%b addr=%0d required %b,%0d",
                         cyc, mem_rd_en_o, mem_rd_addr_o, v, idx);
            end
            acc1 = v;
            idx1 = idx[8:0];
            if (v) begin
                pre1         = ref_tab[idx];
                post1        = ref_upd(pre1, two, b0, b1);
                ref_tab[idx] = post1;
            end
            tick();
        end
        upd_valid_i = 1'b0;
        ram_err = 0;
        for (int k = 0; k < 8; k++) if (ram[k] !== ref_tab[k]) ram_err++;
        n_tests++;
        if (ram_err != 0) begin
            n_fail++;
            $display("FAIL rnd_table: %0d entries differ from model, required 0", ram_err);
        end
    endtask

    task automatic test_init_during_run();
        preload(20, 7'h05);
        preload(21, 7'h4A);
        upd_valid_i = 1'b1;
        upd_idx_i   = 9'd20;
        upd_two_i   = 1'b0;
        upd_bin0_i  = 1'b0;
        upd_bin1_i  = 1'b0;
        tick();
        upd_idx_i    = 9'd21;
        init_start_i = 1'b1;
        #1;
        n_tests++;
        if (upd_ready_o !== 1'b1 || mem_rd_en_o !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_last_accept: rdy=%b rd=%b required 1,1", upd_ready_o, mem_rd_en_o);
        end
        tick();
        init_start_i = 1'b0;
        upd_idx_i    = 9'd22;
        #1;
        n_tests++;
        if (upd_ready_o !== 1'b0 || init_done_o !== 1'b0 || mem_rd_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_ready: rdy=%b done=%b rd=%b required 0,0,0",
                     upd_ready_o, init_done_o, mem_rd_en_o);
        end
        n_tests++;
        if (mem_wr_en_o !== 1'b1 || mem_wr_addr_o !== 9'd20 || mem_wr_data_o !== 7'h06 ||
            ctx_valid_o !== 1'b1 || ctx_o !== 7'h4A) begin
            n_fail++;
            $display("FAIL drain_wr_a: wr=%b addr=%0d data=%h cv=%b ctx=%h required 1,20,06,1,4a",
                     mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o, ctx_valid_o, ctx_o);
        end
        tick();
        n_tests++;
        if (mem_wr_en_o !== 1'b1 || mem_wr_addr_o !== 9'd21 || mem_wr_data_o !== 7'h48 ||
            ctx_valid_o !== 1'b0 || upd_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_wr_b: wr=%b addr=%0d data=%h cv=%b rdy=%b required 1,21,48,0,0",
                     mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o, ctx_valid_o, upd_ready_o);
        end
        tick();
        upd_valid_i = 1'b0;
        n_tests++;
        if (mem_wr_en_o !== 1'b1 || mem_wr_addr_o !== 9'd0 || init_idx_o !== 9'd0 ||
            init_done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_to_init: wr=%b addr=%0d idx=%0d done=%b required 1,0,0,0",
                     mem_wr_en_o, mem_wr_addr_o, init_idx_o, init_done_o);
        end
    endtask

    task automatic test_reset_mid_init();
        int n;
        n = 0;
        while (init_idx_o !== 9'd100 && n < 300) begin
            tick();
            n++;
        end
        n_tests++;
        if (init_idx_o !== 9'd100) begin
            n_fail++;
            $display("FAIL mid_init_reach: idx=%0d required 100", init_idx_o);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (outs_vec() !== '0) begin
            n_fail++;
            $display("FAIL mid_init_reset: got %h required 0", outs_vec());
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (mem_wr_en_o !== 1'b0 || init_idx_o !== 9'd0 || upd_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_idle: wr=%b idx=%0d rdy=%b required 0,0,0",
                         mem_wr_en_o, init_idx_o, upd_ready_o);
            end
        end
        init_start_i = 1'b1;
        tick();
        init_start_i = 1'b0;
        n_tests++;
        if (mem_wr_en_o !== 1'b1 || init_idx_o !== 9'd0) begin
            n_fail++;
            $display("FAIL restart_init: wr=%b idx=%0d required 1,0", mem_wr_en_o, init_idx_o);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init();
        test_next_state();
        test_back_to_back();
        test_random();
        test_init_during_run();
        test_reset_mid_init();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
